// File: rtl/lift_pkg.sv
// Shared encodings for the lift call queue: request codes, lift motion, FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lift_pkg;

    localparam int NUM_CALLS = 6;

    // Request codes presented to the downstream lift FSM
    localparam logic [2:0] REQ_NONE = 3'b000;
    localparam logic [2:0] REQ_1U   = 3'b001;
    localparam logic [2:0] REQ_2U   = 3'b010;
    localparam logic [2:0] REQ_3U   = 3'b011;
    localparam logic [2:0] REQ_2D   = 3'b110;
    localparam logic [2:0] REQ_3D   = 3'b111;
    localparam logic [2:0] REQ_4D   = 3'b100;

    // Motion reported by the lift FSM
    localparam logic [1:0] LIFT_UP   = 2'b00;
    localparam logic [1:0] LIFT_DOWN = 2'b01;
    localparam logic [1:0] LIFT_STAY = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    // Button index (same bit order as btn/pending) to request code
    function automatic logic [2:0] btn_code(input logic [2:0] idx);
        case (idx)
            3'd0:    btn_code = REQ_1U;
            3'd1:    btn_code = REQ_2U;
            3'd2:    btn_code = REQ_3U;
            3'd3:    btn_code = REQ_2D;
            3'd4:    btn_code = REQ_3D;
            3'd5:    btn_code = REQ_4D;
            default: btn_code = REQ_NONE;
        endcase
    endfunction

endpackage

// File: rtl/lift_call_queue_arb.sv
// Combinational 6-way round-robin arbiter: first set req bit at or after ptr, wrapping 5->0.
// Latency: zero cycles (purely combinational).
// Backpressure: none; caller decides whether to accept the grant.
// Ports: req[5:0] candidate calls, ptr[2:0] search start, gnt_idx[2:0] winner, gnt_any any req set.
module lift_rr_arb (
    input  logic [5:0] req,
    input  logic [2:0] ptr,
    output logic [2:0] gnt_idx,
    output logic       gnt_any
);

    logic [3:0] w_idx;

    // Scan offsets from farthest to nearest so the nearest set bit is written last and wins.
    always_comb begin
        gnt_idx = 3'd0;
        gnt_any = 1'b0;
        w_idx   = 4'd0;
        for (int k = 5; k >= 0; k--) begin
            w_idx = {1'b0, ptr} + 4'(k);
            if (w_idx >= 4'd6) begin
                w_idx = w_idx - 4'd6;
            end
            if (req[w_idx[2:0]]) begin
                gnt_idx = w_idx[2:0];
                gnt_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lift_call_queue.sv
// Latches hall-button calls and hands them one at a time to the lift FSM, round-robin.
// Latency: call latched at edge N is issued (req_valid) after edge N+1 when lift is STAY and idle.
// Backpressure: issues only when lift_out==STAY; WAIT holds off until STAY or watchdog timeout.
// Ports: clk, rst_n (sync, active-low), btn[5:0] call pulses, lift_out[1:0] lift motion,
//        req_code[2:0]/req_valid request to lift, pending[5:0] latched calls, busy, timeout pulse.
module lift_call_queue
    import lift_pkg::*;
#(
    parameter int WD_LIMIT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] btn,
    input  logic [1:0] lift_out,
    output logic [2:0] req_code,
    output logic       req_valid,
    output logic [5:0] pending,
    output logic       busy,
    output logic       timeout
);

    state_t     r_state,    w_state_nxt;
    logic [5:0] r_pending,  w_pending_nxt;
    logic [2:0] r_ptr,      w_ptr_nxt;
    logic [3:0] r_wait_cnt, w_wait_cnt_nxt;
    logic [2:0] r_req_code, w_req_code_nxt;
    logic [5:0] w_clr_mask;
    logic [2:0] w_gnt_idx;
    logic       w_gnt_any;
    logic       w_timeout;

    lift_rr_arb u_arb (
        .req     (r_pending),
        .ptr     (r_ptr),
        .gnt_idx (w_gnt_idx),
        .gnt_any (w_gnt_any)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_pending  <= 6'd0;
            r_ptr      <= 3'd0;
            r_wait_cnt <= 4'd0;
            r_req_code <= REQ_NONE;
        end else begin
            r_state    <= w_state_nxt;
            r_pending  <= w_pending_nxt;
            r_ptr      <= w_ptr_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            r_req_code <= w_req_code_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_ptr_nxt      = r_ptr;
        w_wait_cnt_nxt = r_wait_cnt;
        w_req_code_nxt = r_req_code;
        w_clr_mask     = 6'd0;
        w_timeout      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_req_code_nxt = REQ_NONE;
                if (w_gnt_any && (lift_out == LIFT_STAY)) begin
                    w_req_code_nxt = btn_code(w_gnt_idx);
                    w_clr_mask     = 6'b000001 << w_gnt_idx;
                    w_ptr_nxt      = (w_gnt_idx == 3'd5) ? 3'd0 : w_gnt_idx + 3'd1;
                    w_state_nxt    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_req_code_nxt = REQ_NONE;
                w_wait_cnt_nxt = 4'd0;
                w_state_nxt    = ST_WAIT;
            end
            ST_WAIT: begin
                // Arrival (STAY) wins over the watchdog on the same cycle.
                if (lift_out == LIFT_STAY) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_wait_cnt == 4'(WD_LIMIT)) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + 4'd1;
                end
            end
            default: begin
                w_state_nxt    = ST_IDLE;
                w_req_code_nxt = REQ_NONE;
            end
        endcase

        // Clear applied after set: other bits' presses still latch, a press on the
        // granted bit in the grant cycle is absorbed.
        w_pending_nxt = (r_pending | btn) & ~w_clr_mask;
    end

    assign req_code  = r_req_code;
    assign req_valid = (r_req_code != REQ_NONE);
    assign pending   = r_pending;
    assign busy      = (r_state == ST_ISSUE) || (r_state == ST_WAIT);
    assign timeout   = w_timeout;

endmodule

// File: tb/tb_lift_call_queue.sv
module tb_lift_call_queue;

    logic       clk;
    logic       rst_n;
    logic [5:0] btn;
    logic [1:0] lift_out;
    logic [2:0] req_code;
    logic       req_valid;
    logic [5:0] pending;
    logic       busy;
    logic       timeout;

    int n_vec;
    int n_err;

    localparam logic [1:0] UP   = 2'b00;
    localparam logic [1:0] STAY = 2'b10;

    lift_call_queue #(.WD_LIMIT(15)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn       (btn),
        .lift_out  (lift_out),
        .req_code  (req_code),
        .req_valid (req_valid),
        .pending   (pending),
        .busy      (busy),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Packs all visible outputs: {timeout, busy, req_valid, pending[5:0], req_code[2:0]}
    function automatic logic [15:0] outs();
        return {4'd0, timeout, busy, req_valid, pending, req_code};
    endfunction

    function automatic logic [15:0] mk(input logic t, input logic b, input logic v,
                                       input logic [5:0] p, input logic [2:0] c);
        return {4'd0, t, b, v, p, c};
    endfunction

    initial begin
        n_vec    = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        btn      = 6'd0;
        lift_out = STAY;
        tick();
        tick();
        chk("reset_state", outs(), mk(0, 0, 0, 6'd0, 3'b000));
        rst_n = 1'b1;

        // Idle with no calls for 20 cycles
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("idle_quiet", outs(), mk(0, 0, 0, 6'd0, 3'b000));
        end

        // Single 2D call (btn[3])
        btn = 6'b001000;
        tick();
        chk("2d_latched", outs(), mk(0, 0, 0, 6'b001000, 3'b000));
        btn = 6'd0;
        tick();
        chk("2d_issue", outs(), mk(0, 1, 1, 6'd0, 3'b110));
        tick();
        chk("2d_wait", outs(), mk(0, 1, 0, 6'd0, 3'b000));
        tick();
        chk("2d_back_idle", outs(), mk(0, 0, 0, 6'd0, 3'b000));

        // Two simultaneous calls from ptr=0: 1U then 4D, pointer wraps to 0
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        btn = 6'b100001;
        tick();
        chk("rr_latched", outs(), mk(0, 0, 0, 6'b100001, 3'b000));
        btn = 6'd0;
        tick();
        chk("rr_first_1u", outs(), mk(0, 1, 1, 6'b100000, 3'b001));
        lift_out = UP;
        tick();
        tick();
        chk("rr_hold_moving", outs(), mk(0, 1, 0, 6'b100000, 3'b000));
        lift_out = STAY;
        tick();
        chk("rr_idle_again", outs(), mk(0, 0, 0, 6'b100000, 3'b000));
        tick();
        chk("rr_second_4d", outs(), mk(0, 1, 1, 6'd0, 3'b100));
        tick();
        tick();
        btn = 6'b100001;
        tick();
        btn = 6'd0;
        tick();
        chk("rr_ptr_wrapped", outs(), mk(0, 1, 1, 6'b100000, 3'b001));
        tick();
        tick();
        tick();
        chk("rr_drain_4d", outs(), mk(0, 1, 1, 6'd0, 3'b100));
        tick();
        tick();

        // Watchdog: lift moves for the whole WAIT, timeout in 16th WAIT cycle
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        btn = 6'b000001;
        tick();
        btn = 6'd0;
        tick();
        chk("wd_issue", outs(), mk(0, 1, 1, 6'd0, 3'b001));
        lift_out = UP;
        tick();
        for (int k = 1; k <= 15; k++) begin
            chk("wd_no_timeout", outs(), mk(0, 1, 0, 6'd0, 3'b000));
            tick();
        end
        chk("wd_timeout_pulse", outs(), mk(1, 1, 0, 6'd0, 3'b000));
        tick();
        chk("wd_after_timeout", outs(), mk(0, 0, 0, 6'd0, 3'b000));
        lift_out = STAY;

        // 3U: press in grant cycle absorbed, press during ISSUE latches and reissues
        btn = 6'b000100;
        tick();
        chk("abs_latched", outs(), mk(0, 0, 0, 6'b000100, 3'b000));
        tick();
        chk("abs_grant_absorbed", outs(), mk(0, 1, 1, 6'd0, 3'b011));
        tick();
        chk("abs_issue_press", outs(), mk(0, 1, 0, 6'b000100, 3'b000));
        btn = 6'd0;
        lift_out = UP;
        tick();
        chk("abs_wait_hold", outs(), mk(0, 1, 0, 6'b000100, 3'b000));
        lift_out = STAY;
        tick();
        chk("abs_idle", outs(), mk(0, 0, 0, 6'b000100, 3'b000));
        tick();
        chk("abs_reissue", outs(), mk(0, 1, 1, 6'd0, 3'b011));
        tick();
        tick();

        // Reset during WAIT with calls pending; presses during reset are ignored
        btn = 6'b000001;
        tick();
        btn = 6'd0;
        tick();
        chk("rst_issue", outs(), mk(0, 1, 1, 6'd0, 3'b001));
        lift_out = UP;
        tick();
        btn = 6'b011000;
        tick();
        btn = 6'd0;
        chk("rst_pending_set", outs(), mk(0, 1, 0, 6'b011000, 3'b000));
        rst_n = 1'b0;
        btn = 6'b111111;
        tick();
        chk("rst_cleared", outs(), mk(0, 0, 0, 6'd0, 3'b000));
        rst_n = 1'b1;
        btn = 6'd0;
        lift_out = STAY;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("rst_no_reissue", outs(), mk(0, 0, 0, 6'd0, 3'b000));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
